pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the 6-bit `stall` vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. It sequences exception flushes with a small state machine and supplies the restart PC. It also keeps stall and flush statistics plus a stall-watchdog status bit for debug.

## Interface
- `MAX_STALL`, default 1023: consecutive stalled cycles that trip the watchdog (must be ≥ 1).
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: core clock. All state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high (`RstEnable`).
- `stallreq_if` in 1: instruction fetch not ready.
- `stallreq_id` in 1: load-use hazard in decode.
- `stallreq_ex` in 1: multi-cycle EX operation (mul/div) busy.
- `stallreq_mem` in 1: data memory not ready.
- `excp_valid` in 1: exception committed in MEM this cycle (single-cycle pulse).
- `excp_vector` in 32 (`RegBus`): handler address accompanying `excp_valid`.
- `stall` out 6: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. Uses `Stop`=1, `NoStop`=0.
- `flush` out 1: clears all pipeline registers and redirects PC.
- `new_pc` out 32: restart address, valid while `flush`=1.
- `stall_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out CNT_W: saturating count of cycles with `stall[0]`=Stop.
- `flush_count` out 16: saturating count of flushes.

## Operation
- **FSM states: RUN, FLUSH.**
  - Reset enters RUN.
  - RUN → FLUSH when `excp_valid`=1 is sampled.
  - FLUSH → RUN unconditionally after one cycle.
- **`stall` decode in RUN** (combinational, fixed priority mem > ex > id > if):
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000
  - Stage k with `stall[k]`=Stop and `stall[k+1]`=NoStop inserts a bubble downstream. This is the pipeline-register contract.
- **In FLUSH:** `stall`=000000 regardless of requests; `flush`=1; `new_pc`=vector captured at the RUN→FLUSH edge.
- **`excp_valid` in RUN outranks all stall requests in that cycle:**
  - `stall` is forced to 000000 in the same cycle.
  - The faulting instruction is discarded by the following flush.
- `excp_valid` during FLUSH is ignored: no second flush, vector not recaptured.
- **Watchdog:**
  - `run_len` increments each cycle `stall[0]`=Stop and clears when `stall[0]`=NoStop.
  - When `run_len` reaches MAX_STALL, `stall_timeout` sets and stays set until `rst`.
  - `run_len` saturates at MAX_STALL.
  - The watchdog is status only; it does not alter `stall`.
- **Counters:**
  - `stall_cycles` +1 per cycle with `stall[0]`=Stop.
  - `flush_count` +1 per RUN→FLUSH transition.
  - Both saturate at all-ones and never wrap.

## Timing
- **`stall`:** zero latency, combinational from requests and state. Forced to 000000 while `rst`=1.
- **`flush` / `new_pc`:** registered. `excp_valid` sampled at edge t gives `flush`=1 for exactly the cycle after t, then 0. Back-to-back exceptions produce at most one flush per two cycles.
- **Reset values:**
  - FSM = RUN
  - `flush` = 0
  - `new_pc` = 0 (`ZeroWord`)
  - `stall_timeout` = 0
  - `stall_cycles` = 0
  - `flush_count` = 0
  - `run_len` = 0
- **Reset mid-FLUSH:** `flush` drops to 0 on that same edge, and no count is recorded beyond those already taken.
- **Counter and watchdog updates:** use the `stall` value of the current cycle and become visible next cycle.

## Structure
- Shared `defines.v` holds `RstEnable`, `Stop`, `NoStop`, `RegBus`, `ZeroWord`, and the stall-pattern constants (`STALL_MEM`, `STALL_EX`, `STALL_ID`, `STALL_IF`, `STALL_NONE`). Pipeline registers use the same constants.
- One natural sub-module, `sat_counter`, parameterised by width. It is instantiated for `stall_cycles`, `flush_count`, and `run_len` (with a clear input).
- The FSM and priority decode stay in `pipe_ctrl`.

## Test plan
- **Reset:** hold `rst` 3 cycles with all requests high. Required: `stall`=000000, `flush`=0, all counters 0; on release `stall`=011111 immediately.
- **Priority:** assert `stallreq_id` and `stallreq_ex` together for 4 cycles. Required: `stall`=001111 for 4 cycles; `stall_cycles`=4 one cycle later.
- **Exception over stall:** `stallreq_mem`=1 and `excp_valid`=1 with vector 0x0000_0020. Required: same cycle `stall`=000000; next cycle `flush`=1, `new_pc`=0x20; following cycle `flush`=0; `flush_count`=1.
- **Exception during FLUSH:** `excp_valid` pulses on two consecutive cycles (vectors 0x20, 0x40). Required: single one-cycle flush with `new_pc`=0x20; `flush_count`=1.
- **Watchdog:** with MAX_STALL=8, hold `stallreq_if` for 7 cycles, then 1 idle cycle, then 8 cycles. Required: `stall_timeout` stays 0 after the first burst and is 1 after the 8th cycle of the second burst; it remains 1 until `rst`.
- **Saturation:** with CNT_W=4, stall for 20 cycles. Required: `stall_cycles` holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall patterns, stop/no-stop
// levels, FSM state type and the fixed-priority stall decode.
package pipe_ctrl_pkg;

    localparam int REG_W = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    // Bit k stalls stage k (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic [5:0] stall_decode(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous reset and clear; holds at MAX
// instead of wrapping.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            count_reg <= '0;
        else if (clr)
            count_reg <= '0;
        else if (inc && (count_reg != MAX))
            count_reg <= count_reg + W'(1);
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences exception flushes
// and keeps stall/flush statistics with a sticky stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 1023,  // must be >= 1
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [REG_W-1:0] excp_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [REG_W-1:0] new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count
);

    localparam int              RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    state_t           state_reg, state_next;
    logic [REG_W-1:0] new_pc_reg;
    logic             timeout_reg;
    logic [RUN_W-1:0] run_len;
    logic             take_excp;
    logic             pc_stalled;

    assign take_excp  = (state_reg == RUN) && excp_valid;
    assign pc_stalled = (stall[0] == STOP);

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    // An exception in RUN wins over every stall request so the faulting
    // instruction is not held while the flush is being scheduled.
    always_comb begin
        state_next = state_reg;
        stall      = STALL_NONE;
        flush      = 1'b0;
        case (state_reg)
            RUN: begin
                if (excp_valid)
                    state_next = FLUSH;
                else
                    stall = stall_decode(stallreq_mem, stallreq_ex,
                                         stallreq_id, stallreq_if);
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (rst)
            stall = STALL_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            new_pc_reg <= ZERO_WORD;
        else if (take_excp)
            new_pc_reg <= excp_vector;
    end

    // Set on the edge where run_len reaches MAX_STALL, so it appears together
    // with the saturated run length.
    always_ff @(posedge clk) begin
        if (rst)
            timeout_reg <= 1'b0;
        else if (pc_stalled && (run_len >= RUN_MAX - RUN_W'(1)))
            timeout_reg <= 1'b1;
    end

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pc_stalled),
        .count (stall_cycles)
    );

    sat_counter #(.W(16)) u_flush_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (take_excp),
        .count (flush_count)
    );

    sat_counter #(.W(RUN_W), .MAX(RUN_MAX)) u_run_len (
        .clk   (clk),
        .rst   (rst),
        .clr   (!pc_stalled),
        .inc   (pc_stalled),
        .count (run_len)
    );

    assign new_pc        = new_pc_reg;
    assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for reset, priority and flush
// sequencing, then hand-written watchdog and saturation sequences.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_vector;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [3:0]  stall_cycles;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.MAX_STALL(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_vector   (excp_vector),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // req = {mem, ex, id, if}; expected values hold for the cycle the inputs are applied
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        ev;
        logic [31:0] vec;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_to;
        logic [3:0]  e_sc;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] req, input logic ev, input logic [31:0] vec);
        rst = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_valid  = ev;
        excp_vector = vec;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        drive(1'b1, 4'b1111, 1'b0, 32'h0);

        //           rst  req      ev    vec     stall      fl    pc     to    sc  fc
        tv.push_back('{1'b1, 4'b1111, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b1, 4'b1111, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b1, 4'b1111, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b0, 4'b1111, 1'b0, 32'h00, 6'b011111, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b1, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 1, 0});
        tv.push_back('{1'b0, 4'b0110, 1'b0, 32'h00, 6'b001111, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b0, 4'b0110, 1'b0, 32'h00, 6'b001111, 1'b0, 32'h00, 1'b0, 1, 0});
        tv.push_back('{1'b0, 4'b0110, 1'b0, 32'h00, 6'b001111, 1'b0, 32'h00, 1'b0, 2, 0});
        tv.push_back('{1'b0, 4'b0110, 1'b0, 32'h00, 6'b001111, 1'b0, 32'h00, 1'b0, 3, 0});
        tv.push_back('{1'b0, 4'b0001, 1'b0, 32'h00, 6'b000011, 1'b0, 32'h00, 1'b0, 4, 0});
        tv.push_back('{1'b0, 4'b0011, 1'b0, 32'h00, 6'b000111, 1'b0, 32'h00, 1'b0, 5, 0});
        tv.push_back('{1'b0, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 6, 0});
        tv.push_back('{1'b0, 4'b1000, 1'b1, 32'h20, 6'b000000, 1'b0, 32'h00, 1'b0, 6, 0});
        tv.push_back('{1'b0, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b1, 32'h20, 1'b0, 6, 1});
        tv.push_back('{1'b0, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h20, 1'b0, 6, 1});
        tv.push_back('{1'b1, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h20, 1'b0, 6, 1});
        tv.push_back('{1'b0, 4'b0000, 1'b1, 32'h20, 6'b000000, 1'b0, 32'h00, 1'b0, 0, 0});
        tv.push_back('{1'b0, 4'b1000, 1'b1, 32'h40, 6'b000000, 1'b1, 32'h20, 1'b0, 0, 1});
        tv.push_back('{1'b0, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h20, 1'b0, 0, 1});
        tv.push_back('{1'b0, 4'b0000, 1'b1, 32'h44, 6'b000000, 1'b0, 32'h20, 1'b0, 0, 1});
        tv.push_back('{1'b1, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b1, 32'h44, 1'b0, 0, 2});
        tv.push_back('{1'b0, 4'b0000, 1'b0, 32'h00, 6'b000000, 1'b0, 32'h00, 1'b0, 0, 0});

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].req, tv[i].ev, tv[i].vec);
            #1;
            $display("vec %0d rst=%b req=%b ev=%b stall=%b flush=%b pc=%0h to=%b sc=%0d fc=%0d",
                     i, tv[i].rst, tv[i].req, tv[i].ev, stall, flush, new_pc,
                     stall_timeout, stall_cycles, flush_count);
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].e_stall));
            check($sformatf("v%0d_flush", i), 32'(flush), 32'(tv[i].e_flush));
            check($sformatf("v%0d_new_pc", i), new_pc, tv[i].e_pc);
            check($sformatf("v%0d_timeout", i), 32'(stall_timeout), 32'(tv[i].e_to));
            check($sformatf("v%0d_stall_cycles", i), 32'(stall_cycles), 32'(tv[i].e_sc));
            check($sformatf("v%0d_flush_count", i), 32'(flush_count), 32'(tv[i].e_fc));
        end

        // Watchdog: 7 stalled cycles, one idle, then 8 stalled cycles
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b0, 4'b0001, 1'b0, 32'h0);
            #1;
            check($sformatf("wd_a%0d_timeout", i), 32'(stall_timeout), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 32'h0);
        #1;
        $display("wd idle to=%b sc=%0d", stall_timeout, stall_cycles);
        check("wd_idle_timeout", 32'(stall_timeout), 32'd0);
        check("wd_idle_sc", 32'(stall_cycles), 32'd7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b0, 4'b0001, 1'b0, 32'h0);
            #1;
            check($sformatf("wd_b%0d_timeout", i), 32'(stall_timeout), 32'd0);
            check($sformatf("wd_b%0d_stall", i), 32'(stall), 32'(6'b000011));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 4'b0000, 1'b0, 32'h0);
            #1;
            $display("wd after %0d to=%b sc=%0d", i, stall_timeout, stall_cycles);
            check($sformatf("wd_after%0d_timeout", i), 32'(stall_timeout), 32'd1);
            check($sformatf("wd_after%0d_sc", i), 32'(stall_cycles), 32'd15);
        end

        // Reset clears the sticky flag; then saturation of the 4-bit stall counter
        @(negedge clk);
        drive(1'b1, 4'b0000, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 32'h0);
        #1;
        check("rst_timeout", 32'(stall_timeout), 32'd0);
        check("rst_sc", 32'(stall_cycles), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, 4'b1000, 1'b0, 32'h0);
            #1;
            check($sformatf("sat%0d_sc", i), 32'(stall_cycles), (i < 15) ? i : 15);
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 32'h0);
        #1;
        $display("sat end sc=%0d to=%b", stall_cycles, stall_timeout);
        check("sat_end_sc", 32'(stall_cycles), 32'd15);
        check("sat_end_timeout", 32'(stall_timeout), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
